// File: rtl/eth_tx_mac.sv
// Ethernet TX framer: serialises 32-bit AXI-Stream frames into wire bytes with
// preamble/SFD, minimum-length padding, CRC-32 FCS and inter-frame gap.
module eth_tx_mac #(
    parameter int IFG_CYCLES     = 12,
    parameter int MIN_DATA_BYTES = 60
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_tready,
    output logic        err_underrun
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_SFD      = 3'd2;
    localparam logic [2:0] S_DATA     = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_FCS      = 3'd5;
    localparam logic [2:0] S_IFG      = 3'd6;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [10:0] MIN_CNT       = 11'(MIN_DATA_BYTES);
    // The IDLE cycle that accepts the next word is the last gap cycle, so IFG itself is one shorter.
    localparam logic [7:0]  IFG_LAST      = 8'(IFG_CYCLES - 2);

    logic [2:0]  state;
    logic [31:0] word_buf;
    logic        last_word;
    logic [1:0]  byte_sel;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [2:0]  pre_cnt;
    logic [7:0]  ifg_cnt;
    logic        starved;

    logic        m_fire;
    logic        s_fire;
    logic [31:0] crc_next;
    logic [10:0] byte_cnt_inc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        return r;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] sel);
        return w[{sel, 3'b000} +: 8];
    endfunction

    assign m_fire       = m_axis_tvalid & m_axis_tready;
    assign crc_next     = crc_byte(crc, m_axis_tdata);
    assign byte_cnt_inc = (byte_cnt == 11'h7FF) ? byte_cnt : byte_cnt + 11'd1;
    assign s_fire       = s_axis_tvalid & s_axis_tready;

    // Mid-frame words are pulled in the same cycle byte 3 of the current word leaves.
    always_comb begin
        s_axis_tready = 1'b0;
        if (aresetn) begin
            case (state)
                S_IDLE:  s_axis_tready = 1'b1;
                S_DATA:  s_axis_tready = starved |
                                         ((byte_sel == 2'd3) & m_axis_tready & !last_word);
                default: s_axis_tready = 1'b0;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= S_IDLE;
            word_buf      <= '0;
            last_word     <= 1'b0;
            byte_sel      <= '0;
            byte_cnt      <= '0;
            crc           <= '1;
            pre_cnt       <= '0;
            ifg_cnt       <= '0;
            starved       <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            err_underrun  <= 1'b0;
        end else begin
            err_underrun <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (s_fire) begin
                        word_buf      <= s_axis_tdata;
                        last_word     <= s_axis_tlast;
                        byte_sel      <= '0;
                        byte_cnt      <= '0;
                        crc           <= 32'hFFFF_FFFF;
                        pre_cnt       <= '0;
                        m_axis_tdata  <= PREAMBLE_BYTE;
                        m_axis_tvalid <= 1'b1;
                        state         <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (m_fire) begin
                        if (pre_cnt == 3'd6) begin
                            m_axis_tdata <= SFD_BYTE;
                            state        <= S_SFD;
                        end else begin
                            pre_cnt <= pre_cnt + 3'd1;
                        end
                    end
                end
                S_SFD: begin
                    if (m_fire) begin
                        m_axis_tdata <= byte_of(word_buf, 2'd0);
                        byte_sel     <= '0;
                        state        <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (starved) begin
                        if (s_fire) begin
                            word_buf      <= s_axis_tdata;
                            last_word     <= s_axis_tlast;
                            byte_sel      <= '0;
                            m_axis_tdata  <= s_axis_tdata[7:0];
                            m_axis_tvalid <= 1'b1;
                            starved       <= 1'b0;
                        end
                    end else if (m_fire) begin
                        crc      <= crc_next;
                        byte_cnt <= byte_cnt_inc;
                        if (byte_sel != 2'd3) begin
                            byte_sel     <= byte_sel + 2'd1;
                            m_axis_tdata <= byte_of(word_buf, byte_sel + 2'd1);
                        end else if (!last_word) begin
                            if (s_axis_tvalid) begin
                                word_buf     <= s_axis_tdata;
                                last_word    <= s_axis_tlast;
                                byte_sel     <= '0;
                                m_axis_tdata <= s_axis_tdata[7:0];
                            end else begin
                                m_axis_tvalid <= 1'b0;
                                err_underrun  <= 1'b1;
                                starved       <= 1'b1;
                            end
                        end else if (byte_cnt_inc < MIN_CNT) begin
                            m_axis_tdata <= 8'h00;
                            state        <= S_PAD;
                        end else begin
                            m_axis_tdata <= ~crc_next[7:0];
                            byte_sel     <= '0;
                            state        <= S_FCS;
                        end
                    end
                end
                S_PAD: begin
                    if (m_fire) begin
                        crc      <= crc_next;
                        byte_cnt <= byte_cnt_inc;
                        if (byte_cnt_inc >= MIN_CNT) begin
                            m_axis_tdata <= ~crc_next[7:0];
                            byte_sel     <= '0;
                            state        <= S_FCS;
                        end
                    end
                end
                S_FCS: begin
                    if (m_fire) begin
                        if (byte_sel == 2'd3) begin
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            ifg_cnt       <= '0;
                            state         <= S_IFG;
                        end else begin
                            byte_sel     <= byte_sel + 2'd1;
                            m_axis_tdata <= ~byte_of(crc, byte_sel + 2'd1);
                            m_axis_tlast <= (byte_sel == 2'd2);
                        end
                    end
                end
                S_IFG: begin
                    if (ifg_cnt >= IFG_LAST)
                        state <= S_IDLE;
                    else
                        ifg_cnt <= ifg_cnt + 8'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_tx_mac.sv
// Bench for eth_tx_mac: frames are pushed to a source queue and their expected wire
// bytes to a scoreboard, which a negedge monitor pops on every output handshake.
module tb_eth_tx_mac;

    localparam int IFG_CYCLES     = 12;
    localparam int MIN_DATA_BYTES = 60;
    localparam int TIMEOUT_CYCLES = 2000;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tready = 1'b1;
    logic        err_underrun;

    eth_tx_mac #(
        .IFG_CYCLES     (IFG_CYCLES),
        .MIN_DATA_BYTES (MIN_DATA_BYTES)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .err_underrun  (err_underrun)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          gap;
    } src_word_t;

    typedef struct {
        int n_words;
        int pattern;
        int rand_ready;
        int gap_word;
        int exp_len;
        int exp_underruns;
        int low_mode;
    } frame_vec_t;

    src_word_t  src_q[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp_byte;

    int compared = 0;
    int mismatched = 0;
    bit rand_ready = 1'b0;
    bit s_fire_seen = 1'b0;

    int frame_bytes = 0;
    int frame_low = 0;
    int last_frame_len = 0;
    int last_frame_low = 0;
    int frames_done = 0;
    int underruns = 0;
    int gap_cnt = 0;
    int last_gap = -1;
    bit after_tlast = 1'b0;
    bit stall_prev = 1'b0;
    logic [7:0] stall_data = '0;
    logic       stall_last = 1'b0;

    task automatic check_output(input string name, input longint actual, input longint expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] crc_model_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = {1'b0, r[31:1]} ^ (fb ? 32'hEDB88320 : 32'h0);
        end
        return r;
    endfunction

    // Queues the frame's words upstream and its full expected wire image in the scoreboard.
    task automatic apply_stimulus(input int n_words, input int pattern, input int gap_word, input int gap_len);
        logic [7:0]  data[$];
        logic [31:0] w;
        logic [31:0] crc;
        src_word_t   sw;
        for (int i = 0; i < n_words; i++) begin
            case (pattern)
                0:       w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
                1:       w = 32'h0;
                default: w = $urandom;
            endcase
            sw.data = w;
            sw.last = (i == n_words - 1);
            sw.gap  = (gap_word >= 0 && i == gap_word + 1) ? gap_len : 0;
            src_q.push_back(sw);
            for (int b = 0; b < 4; b++) data.push_back(w[8*b +: 8]);
        end
        while (data.size() < MIN_DATA_BYTES) data.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        foreach (data[k]) crc = crc_model_step(crc, data[k]);
        crc = ~crc;
        repeat (7) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        foreach (data[k]) exp_q.push_back({1'b0, data[k]});
        for (int b = 0; b < 4; b++) exp_q.push_back({(b == 3), crc[8*b +: 8]});
    endtask

    task automatic wait_frames(input int target, input string name);
        int cycles;
        cycles = 0;
        while (frames_done < target && cycles < TIMEOUT_CYCLES) begin
            @(negedge aclk);
            #1;
            cycles++;
        end
        check_output(name, frames_done, target);
    endtask

    // Upstream source and downstream ready, driven just after each rising edge.
    always @(posedge aclk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (s_fire_seen && src_q.size() > 0) void'(src_q.pop_front());
        if (src_q.size() > 0) begin
            if (src_q[0].gap > 0) begin
                s_axis_tvalid = 1'b0;
                src_q[0].gap  = src_q[0].gap - 1;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0].data;
                s_axis_tlast  = src_q[0].last;
            end
        end else begin
            s_axis_tvalid = 1'b0;
        end
    end

    // Output monitor: scoreboard compare, hold-while-stalled check, frame and gap bookkeeping.
    always @(negedge aclk) begin
        s_fire_seen = aresetn && s_axis_tvalid && s_axis_tready;
        if (!aresetn) begin
            frame_bytes = 0;
            frame_low   = 0;
            stall_prev  = 1'b0;
            after_tlast = 1'b0;
        end else begin
            if (err_underrun) underruns++;
            if (stall_prev) begin
                check_output("hold tvalid", m_axis_tvalid, 1);
                check_output("hold tdata", m_axis_tdata, stall_data);
                check_output("hold tlast", m_axis_tlast, stall_last);
            end
            if (m_axis_tvalid) begin
                if (after_tlast) begin
                    last_gap    = gap_cnt;
                    after_tlast = 1'b0;
                end
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL unexpected byte: got 0x%02h tlast %0b, expected none",
                                 m_axis_tdata, m_axis_tlast);
                    end else begin
                        exp_byte = exp_q.pop_front();
                        check_output("wire byte {tlast,data}", {m_axis_tlast, m_axis_tdata}, exp_byte);
                    end
                    frame_bytes++;
                    if (m_axis_tlast) begin
                        frames_done++;
                        last_frame_len = frame_bytes;
                        last_frame_low = frame_low;
                        frame_bytes    = 0;
                        frame_low      = 0;
                        after_tlast    = 1'b1;
                        gap_cnt        = 0;
                    end
                end
            end else begin
                if (after_tlast) gap_cnt++;
                if (frame_bytes > 0) frame_low++;
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            stall_data = m_axis_tdata;
            stall_last = m_axis_tlast;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        frame_vec_t vecs[6];
        int target;
        int cycles;
        int frames_before;

        // low_mode: 0 = no tvalid gaps inside the frame, 1 = at least one gap, 2 = not checked
        vecs[0] = '{15, 0, 0, -1, 72, 0, 0};
        vecs[1] = '{ 1, 1, 0, -1, 72, 0, 0};
        vecs[2] = '{20, 0, 1, -1, 92, 0, 2};
        vecs[3] = '{10, 0, 0,  3, 72, 1, 1};
        vecs[4] = '{14, 2, 0, -1, 72, 0, 0};
        vecs[5] = '{16, 2, 0, -1, 76, 0, 0};

        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check_output("reset m_tdata", m_axis_tdata, 0);
        check_output("reset m_tvalid", m_axis_tvalid, 0);
        check_output("reset m_tlast", m_axis_tlast, 0);
        check_output("reset err_underrun", err_underrun, 0);
        check_output("reset s_tready", s_axis_tready, 0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);

        for (int v = 0; v < 6; v++) begin
            @(negedge aclk);
            #1;
            rand_ready = (vecs[v].rand_ready != 0);
            underruns  = 0;
            target     = frames_done + 1;
            apply_stimulus(vecs[v].n_words, vecs[v].pattern, vecs[v].gap_word, 5);
            wait_frames(target, "frame completed");
            check_output("frame length", last_frame_len, vecs[v].exp_len);
            check_output("underrun pulses", underruns, vecs[v].exp_underruns);
            if (vecs[v].low_mode == 0)
                check_output("tvalid gaps in frame", last_frame_low, 0);
            else if (vecs[v].low_mode == 1)
                check_output("tvalid gap during underrun", (last_frame_low > 0), 1);
            check_output("scoreboard drained", exp_q.size(), 0);
            rand_ready = 1'b0;
            repeat (IFG_CYCLES + 4) @(negedge aclk);
        end

        // Back-to-back frames with the upstream always valid.
        #1;
        target = frames_done + 1;
        apply_stimulus(16, 0, -1, 0);
        apply_stimulus(16, 2, -1, 0);
        wait_frames(target, "b2b first frame");
        check_output("b2b first length", last_frame_len, 76);
        wait_frames(target + 1, "b2b second frame");
        check_output("b2b second length", last_frame_len, 76);
        check_output("inter-frame gap", last_gap, IFG_CYCLES);
        repeat (IFG_CYCLES + 4) @(negedge aclk);

        // Reset pulse while data byte 20 is on the wire.
        #1;
        frames_before = frames_done;
        apply_stimulus(16, 0, -1, 0);
        cycles = 0;
        while (frame_bytes < 28 && cycles < TIMEOUT_CYCLES) begin
            @(negedge aclk);
            #1;
            cycles++;
        end
        check_output("reached data byte 20", frame_bytes, 28);
        @(posedge aclk);
        #2;
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        src_q.delete();
        exp_q.delete();
        @(negedge aclk);
        check_output("s_tready held in reset", s_axis_tready, 0);
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(negedge aclk);
        check_output("mid-frame reset m_tdata", m_axis_tdata, 0);
        check_output("mid-frame reset m_tvalid", m_axis_tvalid, 0);
        check_output("mid-frame reset m_tlast", m_axis_tlast, 0);
        check_output("mid-frame reset err_underrun", err_underrun, 0);
        check_output("abandoned frame has no tlast", frames_done, frames_before);
        repeat (2) @(negedge aclk);
        #1;
        target = frames_done + 1;
        apply_stimulus(15, 2, -1, 0);
        wait_frames(target, "frame after reset");
        check_output("frame after reset length", last_frame_len, 72);
        check_output("frame after reset tvalid gaps", last_frame_low, 0);
        check_output("scoreboard drained after reset", exp_q.size(), 0);
        repeat (4) @(negedge aclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/eth_tx_mac.md
# eth_tx_mac

Transmit MAC framer for the Ethernet TX path, sitting directly downstream of the TX clock-domain-crossing frame FIFO. It consumes complete 32-bit AXI-Stream frames (destination MAC through end of payload), serialises them to a byte stream, and prepends preamble/SFD, pads short frames to minimum length, appends the CRC-32 FCS, and enforces the inter-frame gap. Its byte-wide output feeds the PHY interface adapter.

## Interface
- `IFG_CYCLES`, 12: idle cycles after the last FCS byte before the next preamble.
- `MIN_DATA_BYTES`, 60: minimum data+pad bytes before FCS.
- `aclk` in 1: single clock; all logic on rising edge.
- `aresetn` in 1: synchronous, active-low reset.
- `s_axis_tdata` in 32: frame words; byte order on wire is [7:0], [15:8], [23:16], [31:24]. All words are full.
- `s_axis_tvalid` in 1: upstream word valid.
- `s_axis_tlast` in 1: marks final word of frame.
- `s_axis_tready` out 1: word accepted when tvalid & tready.
- `m_axis_tdata` out 8: wire byte.
- `m_axis_tvalid` out 1: byte valid.
- `m_axis_tlast` out 1: high on the final FCS byte only.
- `m_axis_tready` in 1: PHY accepts byte.
- `err_underrun` out 1: one-cycle pulse when a mid-frame word is needed and not available.

## Operation
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG.
- IDLE: `s_axis_tready` = 1. On s handshake, latch word and its tlast into word buffer, clear byte counter, CRC <= 0xFFFFFFFF, load `m_axis_tdata`=0x55, `m_axis_tvalid`=1, go PREAMBLE.
- PREAMBLE: 7 bytes of 0x55 total; after the 7th accepted, present 0xD5, go SFD.
- SFD: on accept, present buffer byte 0, go DATA.
- DATA: each accepted byte advances byte select 0..3, updates CRC, increments data byte counter (11-bit, saturating at 2047). When byte 3 of a non-last word is accepted, the next word must be taken in the same cycle: `s_axis_tready` is combinational = (state==DATA) & byte_sel==3 & m_axis_tready & !last_word. If `s_axis_tvalid` is low then: `m_axis_tvalid` drops to 0, `err_underrun` pulses once, block waits in DATA with `s_axis_tready`=1 until a word arrives, then resumes with tvalid=1 and byte 0 of the new word.
- After byte 3 of the last word: if counter < MIN_DATA_BYTES go PAD presenting 0x00, else go FCS presenting FCS byte 0.
- PAD: 0x00 bytes, included in CRC and counter, until counter == MIN_DATA_BYTES; then FCS.
- CRC: IEEE 802.3 CRC-32, reflected poly 0xEDB88320, init 0xFFFFFFFF, computed byte-wise over data+pad; FCS = ~CRC, sent LSB byte first (FCS[7:0] first).
- FCS: 4 bytes; the 4th carries `m_axis_tlast`=1. On its accept: tvalid/tlast <= 0, go IFG.
- IFG: count IFG_CYCLES cycles with `m_axis_tvalid`=0, `s_axis_tready`=0; then IDLE.
- `s_axis_tready` is 0 in PREAMBLE, SFD, PAD, FCS, IFG.

## Timing
- Reset values: `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `err_underrun`=0, `s_axis_tready`=0 while aresetn low; state IDLE, counters 0.
- `m_axis_*` are registered; once `m_axis_tvalid`=1, tdata/tlast hold until m handshake.
- Latency: first 0x55 appears the cycle after the IDLE word handshake.
- Wire bytes per frame: 8 + max(4N, 60) + 4; with tready stuck 1 and no underrun, exactly that many consecutive tvalid cycles.
- Frame-to-frame minimum: IFG_CYCLES tvalid-low cycles between tlast byte and next 0x55.
- Reset mid-frame: next edge all outputs at reset values, frame abandoned without tlast; upstream remainder of frame is not drained by this block.
- A 1-word frame with tlast: no further upstream word read; pads 56 bytes.

## Test plan
- 15-word frame, words 0x03020100, 0x07060504, ...; tready=1 -> 7×0x55, 0xD5, bytes 0x00..0x3B in order, 0 pad, 4 FCS bytes equal to ~CRC matching zlib.crc32 of the 60 bytes, tlast on byte 72 only.
- 1-word frame 0x00000000 -> 4 data bytes + 56 bytes 0x00, FCS = zlib.crc32 of 60 zero bytes, LSB first, 72 wire bytes total.
- Two back-to-back 16-word frames, upstream always valid -> exactly 12 tvalid-low cycles between first tlast and second 0x55.
- Random m_axis_tready (50%) on 20-word frame -> byte sequence identical to tready=1 run; tdata stable while tvalid & !tready.
- Upstream tvalid dropped for 5 cycles after word 3 -> one `err_underrun` pulse, tvalid low during gap, stream resumes with byte 0 of word 4, FCS still correct.
- aresetn low for 1 cycle in DATA at byte 20 -> outputs all 0 next cycle, no tlast; new frame afterward transmits correctly from preamble.
